jtcop_obj_dma: RTL and testbench

//  Object-table DMA and double buffer feeding the sprite line drawer.
//  On a CPU DMA strobe it takes the CPU bus and copies the object RAM
//  (256 objects x 4 words) into the back bank of a 2x1024x16 table.
//  The front bank serves the drawer's tbl_addr/tbl_dout port.

---
 rtl/jtcop_obj_dma.sv | 151 +++++++++++++++
 tb/tb_jtcop_obj_dma.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtcop_obj_dma.sv
// Object-table DMA with a double-buffered 2x(2**AW)x16 table for the sprite line drawer.
// Optional macro JTCOP_OBJ_AUTODMA_EN: every vblank start also requests a copy.
module jtcop_obj_dma #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          LVBL,
  input  logic          dma_we,
  output logic          bus_req,
  input  logic          bus_ack,
  output logic [AW-1:0] oram_addr,
  input  logic [15:0]   oram_dout,
  input  logic [AW-1:0] tbl_addr,
  output logic [15:0]   tbl_dout,
  output logic          dma_busy,
  output logic          bank
);

`ifdef JTCOP_OBJ_AUTODMA_EN
  localparam logic AUTO_DMA = 1'b1;
`else
  localparam logic AUTO_DMA = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    COPY  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic          pending_r, pending_s;
  logic          ready_r, ready_s;
  logic          lvbl_l_r;
  logic          vld_d_r, vld_d_s;
  logic [AW-1:0] addr_d_r, addr_d_s;
  logic [AW-1:0] oram_addr_s;
  logic          bus_req_s, dma_busy_s, bank_s;
  logic          vb_fall_s, swap_s, last_s;
  logic [15:0]   mem_r [0:(2**(AW+1))-1];

  assign vb_fall_s = lvbl_l_r & ~LVBL;
  // Banks only swap while the bus is free, so a copy never straddles a swap
  assign swap_s    = vb_fall_s & ready_r & (state_r == IDLE);
  assign last_s    = &oram_addr;

  // Next-state and next-output logic for the copy sequencer
  always_comb begin
    state_s     = state_r;
    pending_s   = pending_r | dma_we;
    ready_s     = swap_s ? 1'b0 : ready_r;
    bank_s      = swap_s ? ~bank : bank;
    bus_req_s   = bus_req;
    dma_busy_s  = dma_busy;
    oram_addr_s = oram_addr;
    addr_d_s    = addr_d_r;
    vld_d_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (pending_r || dma_we) begin
          state_s    = REQ;
          pending_s  = 1'b0;
          ready_s    = 1'b0;
          bus_req_s  = 1'b1;
          dma_busy_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (bus_ack) begin
          state_s     = COPY;
          oram_addr_s = {AW{1'b0}};
        end else begin
          state_s = REQ;
        end
      end
      COPY: begin
        if (bus_ack) begin
          vld_d_s  = 1'b1;
          addr_d_s = oram_addr;
          // The address counter stops at the top word; no wrap back to zero
          if (last_s) begin
            state_s = FLUSH;
          end else begin
            oram_addr_s = oram_addr + AW'(1);
          end
        end else begin
          vld_d_s = 1'b0;
        end
      end
      FLUSH: begin
        state_s    = IDLE;
        bus_req_s  = 1'b0;
        dma_busy_s = 1'b0;
        ready_s    = 1'b1;
      end
      default: begin
        state_s    = IDLE;
        bus_req_s  = 1'b0;
        dma_busy_s = 1'b0;
      end
    endcase
    pending_s = pending_s | (AUTO_DMA & vb_fall_s);
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk) begin
    lvbl_l_r <= LVBL;
    if (rst) begin
      state_r   <= IDLE;
      pending_r <= 1'b0;
      ready_r   <= 1'b0;
      vld_d_r   <= 1'b0;
      addr_d_r  <= {AW{1'b0}};
      oram_addr <= {AW{1'b0}};
      bus_req   <= 1'b0;
      dma_busy  <= 1'b0;
      bank      <= 1'b0;
    end else begin
      state_r   <= state_s;
      pending_r <= pending_s;
      ready_r   <= ready_s;
      vld_d_r   <= vld_d_s;
      addr_d_r  <= addr_d_s;
      oram_addr <= oram_addr_s;
      bus_req   <= bus_req_s;
      dma_busy  <= dma_busy_s;
      bank      <= bank_s;
    end
  end

  // Table write port: copied words land in the back bank
  always_ff @(posedge clk) begin
    if (vld_d_r) begin
      mem_r[{~bank, addr_d_r}] <= oram_dout;
    end
  end

  // Drawer read port on the front bank
  always_ff @(posedge clk) begin
    if (rst) begin
      tbl_dout <= 16'h0000;
    end else begin
      tbl_dout <= mem_r[{bank, tbl_addr}];
    end
  end

endmodule

// File: tb/tb_jtcop_obj_dma.sv
// Self-checking bench for jtcop_obj_dma: per-cycle comparison against a transaction-level
// model (ack counting, whole-table snapshots) plus literal expectations.
module tb_jtcop_obj_dma;
  localparam int AW = 10;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, LVBL, dma_we, bus_ack;
  logic          bus_req, dma_busy, bank;
  logic [AW-1:0] oram_addr, tbl_addr;
  logic [15:0]   oram_dout, tbl_dout;
  logic [15:0]   oram [0:N-1];
  logic [15:0]   lfsr = 16'hACE1;
  int            n_chk = 0;
  int            n_pass = 0;
  bit            chk_en = 1'b0;

  always #5 clk = ~clk;

  jtcop_obj_dma #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .LVBL(LVBL), .dma_we(dma_we),
    .bus_req(bus_req), .bus_ack(bus_ack), .oram_addr(oram_addr),
    .oram_dout(oram_dout), .tbl_addr(tbl_addr), .tbl_dout(tbl_dout),
    .dma_busy(dma_busy), .bank(bank)
  );

  // Object RAM: one clock read latency
  always @(posedge clk) oram_dout <= oram[oram_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Model: the block owns the bus from a request until 1025 granted clocks have
  // elapsed plus one flush clock; the finished copy is a snapshot of the object RAM.
  logic [15:0] m_ram [0:1][0:N-1];
  bit          m_valid [0:1];
  bit          m_req, m_busy, m_bank, m_ready, m_pend, m_fl, m_lv, m_known;
  int          m_acks;
  logic [15:0] m_dout;

  always @(posedge clk) begin : model
    bit fall, swap, start, nxt_pend;
    int bk;
    if (rst) begin
      m_req = 1'b0; m_busy = 1'b0; m_bank = 1'b0; m_ready = 1'b0; m_pend = 1'b0;
      m_fl = 1'b0; m_acks = 0; m_dout = 16'h0000; m_known = 1'b1; m_lv = LVBL;
    end else begin
      fall = m_lv && !LVBL;
      m_lv = LVBL;
      m_dout  = m_ram[m_bank ? 1 : 0][tbl_addr];
      m_known = m_valid[m_bank ? 1 : 0];
      swap = fall && m_ready && !m_req;
      start = 1'b0;
      nxt_pend = m_pend || dma_we;
      if (m_req) begin
        if (m_fl) begin
          bk = m_bank ? 0 : 1;
          for (int a = 0; a < N; a++) m_ram[bk][a] = oram[a];
          m_valid[bk] = 1'b1;
          m_req = 1'b0; m_busy = 1'b0; m_ready = 1'b1; m_fl = 1'b0;
        end else if (bus_ack) begin
          m_acks++;
          if (m_acks == N + 1) m_fl = 1'b1;
        end
      end else if (nxt_pend) begin
        start = 1'b1;
        m_req = 1'b1; m_busy = 1'b1; m_acks = 0; m_ready = 1'b0;
        nxt_pend = 1'b0;
      end
`ifdef JTCOP_OBJ_AUTODMA_EN
      if (fall) nxt_pend = 1'b1;
`endif
      m_pend = nxt_pend;
      if (swap) begin
        m_bank = !m_bank;
        m_ready = 1'b0;
      end
      if (start) m_valid[m_bank ? 0 : 1] = 1'b0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("bus_req", 32'(bus_req), 32'(m_req));
      check("dma_busy", 32'(dma_busy), 32'(m_busy));
      check("bank", 32'(bank), 32'(m_bank));
      if (m_known) check("tbl_dout", 32'(tbl_dout), 32'(m_dout));
    end
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic fill(input int pat);
    for (int a = 0; a < N; a++) begin
      case (pat)
        0: oram[a] = 16'(a) ^ 16'hA5A5;
        1: oram[a] = 16'(a * 37 + 32'h1234);
        2: oram[a] = 16'(a) ^ 16'h5A00;
        3: oram[a] = 16'(a) + 16'h0100;
        default: oram[a] = ~16'(a);
      endcase
    end
  endtask

  task automatic pulse_we();
    dma_we = 1'b1;
    step(1);
    dma_we = 1'b0;
  endtask

  task automatic vblank();
    LVBL = 1'b0;
    step(4);
    LVBL = 1'b1;
    step(2);
  endtask

  task automatic wait_idle(input bit rnd, input int limit, output int n);
    n = 0;
    while (bus_req && n < limit) begin
      if (rnd) begin
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        bus_ack = lfsr[0];
      end
      step(1);
      n++;
    end
    check("copy_done_in_time", 32'(bus_req), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; LVBL = 1'b1; dma_we = 1'b0; bus_ack = 1'b0; tbl_addr = {AW{1'b0}};
    fill(0);
    step(2);
    chk_en = 1'b1;
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_busy", 32'(dma_busy), 32'd0);
    check("rst_bank", 32'(bank), 32'd0);
    check("rst_dout", 32'(tbl_dout), 32'h0000);
    check("rst_oram_addr", 32'(oram_addr), 32'd0);
    rst = 1'b0;
    step(2);
`ifdef JTCOP_OBJ_AUTODMA_EN
    bus_ack = 1'b1;
    for (int f = 1; f <= 3; f++) begin
      vblank();
      check("auto_req", 32'(bus_req), 32'd1);
      check("auto_bank", 32'(bank), (f == 2) ? 32'd1 : 32'd0);
      step(1100);
    end
    bus_ack = 1'b0;
`else
    // Reset in the middle of a copy
    pulse_we();
    bus_ack = 1'b1;
    step(100);
    rst = 1'b1;
    step(2);
    bus_ack = 1'b0;
    rst = 1'b0;
    check("midrst_bus_req", 32'(bus_req), 32'd0);
    check("midrst_busy", 32'(dma_busy), 32'd0);
    check("midrst_bank", 32'(bank), 32'd0);
    check("midrst_dout", 32'(tbl_dout), 32'h0000);
    step(3);
    vblank();
    check("no_swap_after_rst", 32'(bank), 32'd0);

    // Plain copy, ack three clocks after the strobe
    pulse_we();
    check("req_rise", 32'(bus_req), 32'd1);
    step(2);
    bus_ack = 1'b1;
    wait_idle(1'b0, 3000, n);
    check("req_fall_clks", 32'(n - 1), 32'd1025);
    bus_ack = 1'b0;
    step(2);
    vblank();
    check("bank_after_copy", 32'(bank), 32'd1);
    tbl_addr = 10'h3FF;
    step(1);
    check("dout_3ff", 32'(tbl_dout), 32'h0000A65A);

    // Copy with a stalling grant, then sweep the whole front bank
    fill(1);
    pulse_we();
    wait_idle(1'b1, 8000, n);
    bus_ack = 1'b0;
    step(2);
    vblank();
    check("bank_after_stall", 32'(bank), 32'd0);
    for (int a = 0; a < N; a++) begin
      tbl_addr = 10'(a);
      step(1);
    end
    tbl_addr = 10'h000;
    step(1);
    check("stall_dout_0", 32'(tbl_dout), 32'h00001234);
    tbl_addr = 10'h001;
    step(1);
    check("stall_dout_1", 32'(tbl_dout), 32'h00001259);

    // Vblank edge while the copy is running does not swap
    fill(2);
    pulse_we();
    bus_ack = 1'b1;
    step(500);
    vblank();
    check("bank_hold", 32'(bank), 32'd0);
    tbl_addr = 10'h005;
    step(1);
    check("old_frame", 32'(tbl_dout), 32'h000012ED);
    wait_idle(1'b0, 3000, n);
    bus_ack = 1'b0;
    step(2);
    vblank();
    check("bank_next_edge", 32'(bank), 32'd1);
    step(1);
    check("new_frame", 32'(tbl_dout), 32'h00005A05);

    // Re-trigger during a copy
    fill(3);
    pulse_we();
    bus_ack = 1'b1;
    step(300);
    pulse_we();
    wait_idle(1'b0, 3000, n);
    fill(4);
    n = 0;
    while (!bus_req && n < 10) begin
      step(1);
      n++;
    end
    check("idle_gap", 32'(n), 32'd1);
    step(200);
    vblank();
    check("bank_hold2", 32'(bank), 32'd1);
    wait_idle(1'b0, 3000, n);
    bus_ack = 1'b0;
    step(2);
    vblank();
    check("bank_retrig", 32'(bank), 32'd0);
    tbl_addr = 10'h003;
    step(1);
    check("retrig_dout", 32'(tbl_dout), 32'h0000FFFC);
`endif
    step(2);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
